// File: rtl/ram_fifo_pkg.sv
// ram_fifo_pkg
// Shared sizing for the RAM1 FIFO controller slice.
// Contents:
//   DATA_W  - default data width, matches RAM1 data_in/q
//   ADDR_W  - default address width into RAM1
//   DEPTH   - number of RAM1 words the FIFO may occupy
//   COUNT_W - occupancy counter width, one bit wider than ADDR_W so 0..DEPTH fits
package ram_fifo_pkg;

    localparam int DATA_W  = 4;
    localparam int ADDR_W  = 4;
    localparam int DEPTH   = 2 ** ADDR_W;
    localparam int COUNT_W = ADDR_W + 1;

endpackage

// File: rtl/fifo_ptr.sv
// fifo_ptr
// Wrapping FIFO pointer. Increments by one whenever inc is high and rolls
// from 2**W-1 back to 0 with no gap, giving a circular walk through RAM1.
// Ports:
//   clk - system clock, rising edge
//   rst - synchronous active-high reset, clears the pointer to 0
//   inc - advance the pointer at the next edge
//   ptr - current pointer value (W bits)
module fifo_ptr
    import ram_fifo_pkg::*;
#(
    parameter int W = ADDR_W
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    output logic [W-1:0] ptr
);

    // Natural binary overflow provides the modulo-2**W wrap.
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr <= '0;
        end else if (inc) begin
            ptr <= ptr + 1'b1;
        end
    end

endmodule

// File: rtl/ram_fifo_ctrl.sv
// ram_fifo_ctrl
// FIFO controller in front of the single-port RAM1. Converts push/pop
// requests into RAM1 active-low strobes, address and write data, and tracks
// pointers, occupancy and full/empty. Pop wins over push when both are
// requested and the FIFO holds data; at most one RAM access per cycle.
// Optional build macro RAM_FIFO_ERR_EN enables the sticky err flag
// (overflow/underflow attempts); without it err is tied low.
// Ports:
//   clk, rst              - clock (rising edge), synchronous active-high reset
//   push, push_data       - enqueue request and its data
//   push_ack              - push accepted this cycle (combinational)
//   pop, pop_ack          - dequeue request / accepted this cycle (combinational)
//   pop_data, pop_valid   - RAM1 read data and its registered valid flag
//   full, empty, count    - registered occupancy status
//   err                   - sticky overflow/underflow flag
//   ram_wr_n, ram_rd_n    - RAM1 active-low write/read strobes
//   ram_addr, ram_din     - RAM1 address and write data
//   ram_q                 - RAM1 registered read data
module ram_fifo_ctrl #(
    parameter int DATA_W = ram_fifo_pkg::DATA_W,
    parameter int ADDR_W = ram_fifo_pkg::ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic [DATA_W-1:0] push_data,
    output logic              push_ack,
    input  logic              pop,
    output logic              pop_ack,
    output logic [DATA_W-1:0] pop_data,
    output logic              pop_valid,
    output logic              full,
    output logic              empty,
    output logic [ADDR_W:0]   count,
    output logic              err,
    output logic              ram_wr_n,
    output logic              ram_rd_n,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_din,
    input  logic [DATA_W-1:0] ram_q
);

    localparam int COUNT_W = ADDR_W + 1;
    localparam logic [COUNT_W-1:0] DEPTH_C = COUNT_W'(2 ** ADDR_W);

    logic [ADDR_W-1:0]  wr_ptr;
    logic [ADDR_W-1:0]  rd_ptr;
    logic [COUNT_W-1:0] count_r;
    logic               full_r;
    logic               empty_r;
    logic               pop_valid_r;

    // Acks depend only on registered flags. Reset suppresses both so that a
    // request coinciding with reset never strobes RAM1.
    assign pop_ack  = pop  & ~empty_r & ~rst;
    assign push_ack = push & ~full_r & ~pop_ack & ~rst;

    fifo_ptr #(.W(ADDR_W)) u_wr_ptr (
        .clk (clk),
        .rst (rst),
        .inc (push_ack),
        .ptr (wr_ptr)
    );

    fifo_ptr #(.W(ADDR_W)) u_rd_ptr (
        .clk (clk),
        .rst (rst),
        .inc (pop_ack),
        .ptr (rd_ptr)
    );

    // Idle address parks on rd_ptr; the acks are mutually exclusive, so the
    // two strobes can never be low together.
    always_comb begin
        ram_wr_n = 1'b1;
        ram_rd_n = 1'b1;
        ram_addr = rd_ptr;
        ram_din  = push_data;
        if (pop_ack) begin
            ram_rd_n = 1'b0;
        end else if (push_ack) begin
            ram_wr_n = 1'b0;
            ram_addr = wr_ptr;
        end
    end

    // Flags are computed from the pre-update count so they register in step
    // with the new count.
    always_ff @(posedge clk) begin
        if (rst) begin
            count_r <= '0;
            full_r  <= 1'b0;
            empty_r <= 1'b1;
        end else if (push_ack) begin
            count_r <= count_r + 1'b1;
            full_r  <= (count_r == DEPTH_C - 1'b1);
            empty_r <= 1'b0;
        end else if (pop_ack) begin
            count_r <= count_r - 1'b1;
            full_r  <= 1'b0;
            empty_r <= (count_r == COUNT_W'(1));
        end
    end

    // RAM1 returns data one cycle after the read strobe.
    always_ff @(posedge clk) begin
        if (rst) begin
            pop_valid_r <= 1'b0;
        end else begin
            pop_valid_r <= pop_ack;
        end
    end

`ifdef RAM_FIFO_ERR_EN
    logic err_r;

    // Sticky record of any push-while-full or pop-while-empty attempt.
    always_ff @(posedge clk) begin
        if (rst) begin
            err_r <= 1'b0;
        end else if ((push & full_r) | (pop & empty_r)) begin
            err_r <= 1'b1;
        end
    end

    assign err = err_r;
`else
    assign err = 1'b0;
`endif

    assign pop_data  = ram_q;
    assign pop_valid = pop_valid_r;
    assign full      = full_r;
    assign empty     = empty_r;
    assign count     = count_r;

endmodule

// File: tb/tb_ram_fifo_ctrl.sv
// tb_ram_fifo_ctrl
// Bench for ram_fifo_ctrl with a behavioural RAM1 and a queue-based FIFO
// model. Honours RAM_FIFO_ERR_EN when defined for the err expectations.
module tb_ram_fifo_ctrl;

    logic       clk;
    logic       rst;
    logic       push;
    logic [3:0] push_data;
    logic       push_ack;
    logic       pop;
    logic       pop_ack;
    logic [3:0] pop_data;
    logic       pop_valid;
    logic       full;
    logic       empty;
    logic [4:0] count;
    logic       err;
    logic       ram_wr_n;
    logic       ram_rd_n;
    logic [3:0] ram_addr;
    logic [3:0] ram_din;
    logic [3:0] ram_q;

    int errors = 0;
    int checks = 0;

    ram_fifo_ctrl dut (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_data (push_data),
        .push_ack  (push_ack),
        .pop       (pop),
        .pop_ack   (pop_ack),
        .pop_data  (pop_data),
        .pop_valid (pop_valid),
        .full      (full),
        .empty     (empty),
        .count     (count),
        .err       (err),
        .ram_wr_n  (ram_wr_n),
        .ram_rd_n  (ram_rd_n),
        .ram_addr  (ram_addr),
        .ram_din   (ram_din),
        .ram_q     (ram_q)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural RAM1: write and registered read on the strobed edge.
    logic [3:0] ram_mem [16];
    always @(posedge clk) begin
        if (!ram_wr_n) ram_mem[ram_addr] <= ram_din;
        if (!ram_rd_n) ram_q <= ram_mem[ram_addr];
    end

    // FIFO model: contents as a queue, pointers as running totals mod 16.
    logic [3:0] q_m[$];
    int         pushes_m = 0;
    int         pops_m   = 0;
    bit         pv_m     = 0;
    logic [3:0] pd_m     = '0;
    bit         err_m    = 0;
    bit         live     = 0;

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
        end
    endtask

    always @(posedge clk) begin
        bit pa;
        bit wa;
        pa = pop && (q_m.size() > 0) && !rst;
        wa = push && (q_m.size() < 16) && !pa && !rst;
        if (rst) begin
            q_m.delete();
            pushes_m = 0;
            pops_m   = 0;
            pv_m     = 0;
            err_m    = 0;
            live     = 1;
        end else begin
            if ((push && q_m.size() == 16) || (pop && q_m.size() == 0)) err_m = 1;
            pv_m = pa;
            if (pa) begin
                pd_m = q_m.pop_front();
                pops_m++;
            end
            if (wa) begin
                q_m.push_back(push_data);
                pushes_m++;
            end
        end
    end

    // Per-cycle comparison of every output against the model.
    always @(negedge clk) begin
        bit pa;
        bit wa;
        int addr_e;
        if (live) begin
            pa = pop && (q_m.size() > 0) && !rst;
            wa = push && (q_m.size() < 16) && !pa && !rst;
            addr_e = wa ? (pushes_m % 16) : (pops_m % 16);
            checkOutput("pop_ack", int'(pop_ack), int'(pa));
            checkOutput("push_ack", int'(push_ack), int'(wa));
            checkOutput("ram_rd_n", int'(ram_rd_n), int'(!pa));
            checkOutput("ram_wr_n", int'(ram_wr_n), int'(!wa));
            checkOutput("strobe_excl", int'(!ram_rd_n && !ram_wr_n), 0);
            checkOutput("ram_addr", int'(ram_addr), addr_e);
            if (!pa) checkOutput("ram_din", int'(ram_din), int'(push_data));
            checkOutput("count", int'(count), q_m.size());
            checkOutput("full", int'(full), int'(q_m.size() == 16));
            checkOutput("empty", int'(empty), int'(q_m.size() == 0));
            checkOutput("pop_valid", int'(pop_valid), int'(pv_m));
            if (pv_m) checkOutput("pop_data", int'(pop_data), int'(pd_m));
`ifdef RAM_FIFO_ERR_EN
            checkOutput("err", int'(err), int'(err_m));
`else
            checkOutput("err", int'(err), 0);
`endif
        end
    end

    // Drive one cycle of inputs just after the edge, return after the
    // following falling edge so callers can inspect settled outputs.
    task automatic applyStimulus(input bit r, input bit ps, input int d, input bit pp);
        @(posedge clk);
        #1;
        rst       = r;
        push      = ps;
        push_data = 4'(d);
        pop       = pp;
        @(negedge clk);
        #1;
    endtask

    localparam int ERR_ON =
`ifdef RAM_FIFO_ERR_EN
        1;
`else
        0;
`endif

    initial begin
        rst = 1'b1;
        push = 1'b0;
        pop = 1'b0;
        push_data = '0;

        // Reset state
        applyStimulus(1, 0, 0, 0);
        applyStimulus(1, 0, 0, 0);
        applyStimulus(0, 0, 0, 0);
        checkOutput("rst_count", int'(count), 0);
        checkOutput("rst_empty", int'(empty), 1);
        checkOutput("rst_full", int'(full), 0);
        checkOutput("rst_wr_n", int'(ram_wr_n), 1);
        checkOutput("rst_rd_n", int'(ram_rd_n), 1);
        checkOutput("rst_addr", int'(ram_addr), 0);
        checkOutput("rst_pop_valid", int'(pop_valid), 0);

        // Fill with 0..15
        for (int i = 0; i < 16; i++) begin
            applyStimulus(0, 1, i, 0);
            checkOutput("fill_addr", int'(ram_addr), i);
            checkOutput("fill_wr_n", int'(ram_wr_n), 0);
        end
        applyStimulus(0, 1, 7, 0);
        checkOutput("full_count", int'(count), 16);
        checkOutput("full_flag", int'(full), 1);
        checkOutput("full_push_ack", int'(push_ack), 0);
        checkOutput("full_wr_n", int'(ram_wr_n), 1);

        // Drain
        for (int i = 0; i < 16; i++) begin
            applyStimulus(0, 0, 0, 1);
            checkOutput("drain_addr", int'(ram_addr), i);
            checkOutput("drain_rd_n", int'(ram_rd_n), 0);
            if (i == 1) checkOutput("drain_first_data", int'(pop_data), 0);
        end
        applyStimulus(0, 0, 0, 1);
        checkOutput("drain_last_valid", int'(pop_valid), 1);
        checkOutput("drain_last_data", int'(pop_data), 15);
        checkOutput("drain_empty", int'(empty), 1);
        checkOutput("drain_count", int'(count), 0);
        checkOutput("drain_pop_ack", int'(pop_ack), 0);
        applyStimulus(0, 0, 0, 0);
        checkOutput("err_after_misuse", int'(err), ERR_ON);

        // Wrap-around
        applyStimulus(1, 0, 0, 0);
        applyStimulus(0, 0, 0, 0);
        checkOutput("err_cleared", int'(err), 0);
        for (int i = 0; i < 10; i++) applyStimulus(0, 1, i, 0);
        for (int i = 0; i < 10; i++) applyStimulus(0, 0, 0, 1);
        for (int i = 0; i < 12; i++) begin
            applyStimulus(0, 1, (10 + i) % 16, 0);
            if (i == 6) checkOutput("wrap_wr_addr", int'(ram_addr), 0);
        end
        for (int i = 0; i < 12; i++) begin
            applyStimulus(0, 0, 0, 1);
            if (i == 0) checkOutput("wrap_rd_addr0", int'(ram_addr), 10);
            if (i == 7) checkOutput("wrap_rd_data", int'(pop_data), 0);
        end
        applyStimulus(0, 0, 0, 0);
        checkOutput("wrap_last_data", int'(pop_data), 5);

        // Simultaneous push and pop with three words queued
        applyStimulus(1, 0, 0, 0);
        for (int i = 1; i <= 3; i++) applyStimulus(0, 1, i, 0);
        for (int i = 0; i < 4; i++) begin
            applyStimulus(0, 1, 9, 1);
            if (i < 3) begin
                checkOutput("hold_pop_ack", int'(pop_ack), 1);
                checkOutput("hold_push_ack", int'(push_ack), 0);
            end else begin
                checkOutput("hold_count", int'(count), 0);
                checkOutput("hold_push_wins", int'(push_ack), 1);
            end
        end
        applyStimulus(0, 0, 0, 0);

        // Reset mid-burst with a read in flight
        for (int i = 0; i < 4; i++) applyStimulus(0, 1, 4 + i, 0);
        applyStimulus(0, 0, 0, 1);
        checkOutput("burst_count", int'(count), 5);
        applyStimulus(1, 0, 0, 1);
        checkOutput("burst_pending", int'(pop_valid), 1);
        checkOutput("err_sticky", int'(err), ERR_ON);
        applyStimulus(0, 0, 0, 1);
        checkOutput("post_rst_count", int'(count), 0);
        checkOutput("post_rst_empty", int'(empty), 1);
        checkOutput("post_rst_valid", int'(pop_valid), 0);
        checkOutput("post_rst_rd_n", int'(ram_rd_n), 1);
        checkOutput("post_rst_wr_n", int'(ram_wr_n), 1);
        checkOutput("post_rst_addr", int'(ram_addr), 0);
        applyStimulus(0, 0, 0, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
